// File: rtl/regfile_pkg.sv
// Shared types, defaults and the boot-value rule for the multiport register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [31:0] PROT_MASK_DEF = 32'h0C00_0001;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic logic [31:0] boot_value(
    input logic [31:0] idx,
    input logic        prot,
    input logic [31:0] sp_index,
    input logic [31:0] sp_init,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input logic [31:0] off
  );
    if (prot) return '0;
    if (idx == sp_index) return sp_init;
    if (idx >= lo && idx <= hi) return idx + off;
    return '0;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset sweep: loads one register per cycle with its boot value,
// then hands the array over to the run-time write ports.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [2**ADDR_W-1:0] PROT_MASK = PROT_MASK_DEF,
  parameter int SP_INDEX = 29,
  parameter int SP_INIT = 1023,
  parameter int INIT_LO = 2,
  parameter int INIT_HI = 25,
  parameter int INIT_OFFSET = 100
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              init_busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  state_t state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (state == ST_INIT) begin
      idx_next = idx + 1'b1;
      if (idx == {ADDR_W{1'b1}}) state_next = ST_RUN;
    end
  end

  assign ready     = (state == ST_RUN);
  assign init_busy = ~ready;
  assign init_we   = (state == ST_INIT);
  assign init_addr = idx;
  assign init_data = DATA_W'(boot_value(32'(idx), PROT_MASK[idx],
                                        32'(SP_INDEX), 32'(SP_INIT),
                                        32'(INIT_LO), 32'(INIT_HI),
                                        32'(INIT_OFFSET)));

endmodule

// File: rtl/regfile_multiport.sv
// Register file: two prioritised write ports (B wins), NUM_READ registered reads.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_READ = 2,
  parameter logic [2**ADDR_W-1:0] PROT_MASK = PROT_MASK_DEF,
  parameter int SP_INDEX = 29,
  parameter int SP_INIT = 1023,
  parameter int INIT_LO = 2,
  parameter int INIT_HI = 25,
  parameter int INIT_OFFSET = 100
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                WEnA,
  input  logic [ADDR_W-1:0]                   WAddrA,
  input  logic signed [DATA_W-1:0]            WDataA,
  input  logic                                WEnB,
  input  logic [ADDR_W-1:0]                   WAddrB,
  input  logic signed [DATA_W-1:0]            WDataB,
  input  logic [NUM_READ*ADDR_W-1:0]          ReadReg,
  output logic signed [NUM_READ*DATA_W-1:0]   ReadData,
  output logic                                Ready,
  output logic                                ProtViolation,
  output logic                                InitBusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              wa_ok, wb_ok, pv_next;
  logic [NUM_READ*DATA_W-1:0] rd_next;

  regfile_init_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROT_MASK(PROT_MASK),
    .SP_INDEX(SP_INDEX), .SP_INIT(SP_INIT), .INIT_LO(INIT_LO),
    .INIT_HI(INIT_HI), .INIT_OFFSET(INIT_OFFSET)
  ) u_init (
    .clk(Clk), .rst(Rst), .ready(Ready), .init_busy(InitBusy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  assign wa_ok   = WEnA && !PROT_MASK[WAddrA];
  assign wb_ok   = WEnB && !PROT_MASK[WAddrB];
  assign pv_next = (WEnA && PROT_MASK[WAddrA]) || (WEnB && PROT_MASK[WAddrB]);

  // B is written last so it wins a same-address collision.
  always_ff @(posedge Clk) begin
    if (init_we) begin
      regs[init_addr] <= init_data;
    end else begin
      if (wa_ok) regs[WAddrA] <= WDataA;
      if (wb_ok) regs[WAddrB] <= WDataB;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_READ; k++) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && WAddrB == ReadReg[k*ADDR_W +: ADDR_W])
        rd_next[k*DATA_W +: DATA_W] = WDataB;
      else if (wa_ok && WAddrA == ReadReg[k*ADDR_W +: ADDR_W])
        rd_next[k*DATA_W +: DATA_W] = WDataA;
      else
        rd_next[k*DATA_W +: DATA_W] = regs[ReadReg[k*ADDR_W +: ADDR_W]];
`else
      rd_next[k*DATA_W +: DATA_W] = regs[ReadReg[k*ADDR_W +: ADDR_W]];
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ReadData      <= '0;
      ProtViolation <= 1'b0;
    end else if (init_we) begin
      ReadData      <= '0;
      ProtViolation <= 1'b0;
    end else begin
      ReadData      <= rd_next;
      ProtViolation <= pv_next;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised and directed bench for regfile_multiport against an array model.
module tb_regfile_multiport;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        WEnA = 1'b0;
  logic [4:0]  WAddrA = '0;
  logic [31:0] WDataA = '0;
  logic        WEnB = 1'b0;
  logic [4:0]  WAddrB = '0;
  logic [31:0] WDataB = '0;
  logic [9:0]  ReadReg = '0;
  logic [63:0] ReadData;
  logic        Ready, ProtViolation, InitBusy;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [32];
  logic [31:0] exp_rd [2];
  logic        exp_pv;

  regfile_multiport dut (
    .Clk(Clk), .Rst(Rst),
    .WEnA(WEnA), .WAddrA(WAddrA), .WDataA(WDataA),
    .WEnB(WEnB), .WAddrB(WAddrB), .WDataB(WDataB),
    .ReadReg(ReadReg), .ReadData(ReadData),
    .Ready(Ready), .ProtViolation(ProtViolation), .InitBusy(InitBusy)
  );

  always #5 Clk = ~Clk;

  function automatic bit is_prot(input int i);
    return (i == 0) || (i == 26) || (i == 27);
  endfunction

  function automatic logic [31:0] boot(input int i);
    if (is_prot(i)) return 32'd0;
    if (i == 29) return 32'd1023;
    if (i >= 2 && i <= 25) return 32'(i + 100);
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_boot();
    for (int i = 0; i < 32; i++) model[i] = boot(i);
  endtask

  // One RUN cycle: drive, predict from the model, clock, then commit to model.
  task automatic do_cycle(input logic ea, input logic [4:0] aa,
                          input logic [31:0] da, input logic eb,
                          input logic [4:0] ab, input logic [31:0] db,
                          input logic [4:0] r0, input logic [4:0] r1);
    logic [4:0] rr [2];
    WEnA = ea; WAddrA = aa; WDataA = da;
    WEnB = eb; WAddrB = ab; WDataB = db;
    ReadReg = {r1, r0};
    rr[0] = r0; rr[1] = r1;
    for (int k = 0; k < 2; k++) begin
      exp_rd[k] = model[rr[k]];
`ifdef REGFILE_BYPASS_EN
      if (eb && !is_prot(int'(ab)) && ab == rr[k]) exp_rd[k] = db;
      else if (ea && !is_prot(int'(aa)) && aa == rr[k]) exp_rd[k] = da;
`endif
    end
    exp_pv = (ea && is_prot(int'(aa))) || (eb && is_prot(int'(ab)));
    tick();
    if (ea && !is_prot(int'(aa))) model[aa] = da;
    if (eb && !is_prot(int'(ab))) model[ab] = db;
    WEnA = 1'b0; WEnB = 1'b0;
  endtask

  task automatic test_reset();
    bit seen_early;
    Rst = 1'b1;
    tick();
    checks++;
    if (Ready !== 1'b0 || InitBusy !== 1'b1 || ReadData !== 64'd0 ||
        ProtViolation !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: Ready=%b InitBusy=%b ReadData=%h PV=%b",
               Ready, InitBusy, ReadData, ProtViolation);
    end
    Rst = 1'b0;
    seen_early = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i < 32 && (Ready !== 1'b0 || InitBusy !== 1'b1)) seen_early = 1'b1;
    end
    checks++;
    if (seen_early) begin
      failures++;
      $display("FAIL ready_early: Ready rose before 32 cycles");
    end
    checks++;
    if (Ready !== 1'b1 || InitBusy !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_32: Ready=%b InitBusy=%b want 1/0",
               Ready, InitBusy);
    end
    model_boot();
    for (int i = 0; i < 32; i += 2) begin
      do_cycle(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ReadData[k*32 +: 32] !== boot(i + k)) begin
          failures++;
          $display("FAIL boot_value[%0d]: got %0d want %0d",
                   i + k, ReadData[k*32 +: 32], boot(i + k));
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_cycle(1, 8, -32'sd7, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 8, 5);
    checks++;
    if (ReadData[31:0] !== 32'hFFFF_FFF9 || ReadData[63:32] !== 32'd105) begin
      failures++;
      $display("FAIL write_read: got %h want FFFFFFF9/00000069", ReadData);
    end
  endtask

  task automatic test_same_addr();
    do_cycle(1, 9, 11, 1, 9, 22, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 9, 9);
    checks++;
    if (ReadData[31:0] !== 32'd22 || ReadData[63:32] !== 32'd22) begin
      failures++;
      $display("FAIL same_addr: got %h want 22 on both ports", ReadData);
    end
  endtask

  task automatic test_protect();
    do_cycle(1, 26, 5, 0, 0, 0, 26, 0);
    checks++;
    if (ProtViolation !== 1'b1) begin
      failures++;
      $display("FAIL prot_pulse: got %b want 1", ProtViolation);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 26, 27);
    checks++;
    if (ProtViolation !== 1'b0 || ReadData !== 64'd0) begin
      failures++;
      $display("FAIL prot_hold: PV=%b ReadData=%h want 0/0",
               ProtViolation, ReadData);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'd77;
`else
    want = 32'd110;
`endif
    do_cycle(1, 10, 77, 0, 0, 0, 10, 0);
    checks++;
    if (ReadData[31:0] !== want) begin
      failures++;
      $display("FAIL bypass_same_edge: got %0d want %0d",
               ReadData[31:0], want);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 10, 0);
    checks++;
    if (ReadData[31:0] !== 32'd77) begin
      failures++;
      $display("FAIL bypass_next: got %0d want 77", ReadData[31:0]);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 300; n++) begin
      do_cycle(1'($urandom), 5'($urandom), $urandom,
               1'($urandom), 5'($urandom_range(0, 3) == 0 ? 9 : $urandom),
               $urandom, 5'($urandom), 5'($urandom));
      checks++;
      if (ReadData[31:0] !== exp_rd[0] || ReadData[63:32] !== exp_rd[1] ||
          ProtViolation !== exp_pv) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: got %h/%b want %h%h/%b", n,
                   ReadData, ProtViolation, exp_rd[1], exp_rd[0], exp_pv);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit pv_seen, early;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    Rst = 1'b1;
    #1;
    checks++;
    if (Ready !== 1'b0 || InitBusy !== 1'b1 || ReadData !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset: Ready=%b InitBusy=%b ReadData=%h",
               Ready, InitBusy, ReadData);
    end
    tick();
    Rst = 1'b0;
    WEnA = 1'b1; WAddrA = 5; WDataA = 999;
    WEnB = 1'b1; WAddrB = 26; WDataB = 3;
    pv_seen = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (ProtViolation !== 1'b0) pv_seen = 1'b1;
      if (i < 32 && Ready !== 1'b0) early = 1'b1;
    end
    WEnA = 1'b0; WEnB = 1'b0;
    checks++;
    if (pv_seen) begin
      failures++;
      $display("FAIL init_pv: ProtViolation raised during sweep");
    end
    checks++;
    if (early || Ready !== 1'b1) begin
      failures++;
      $display("FAIL resweep_ready: early=%b Ready=%b want 0/1", early, Ready);
    end
    model_boot();
    do_cycle(0, 0, 0, 0, 0, 0, 5, 26);
    checks++;
    if (ReadData[31:0] !== 32'd105 || ReadData[63:32] !== 32'd0) begin
      failures++;
      $display("FAIL init_write_ignored: got %h want 0/105", ReadData);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 8, 29);
    checks++;
    if (ReadData[31:0] !== 32'd108 || ReadData[63:32] !== 32'd1023) begin
      failures++;
      $display("FAIL resweep_values: got %h want 1023/108", ReadData);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_protect();
    test_bypass();
    test_random();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
